wb_arb_qos: RTL
===============

Name: wb_arb_qos

Overview:
- Quality-of-service arbiter for one Wishbone slave port.
- Drop-in replacement for the round-robin arbiter that selects which of up to four masters drives the shared slave-port mux.
- Adds three features over plain round-robin:
  - grant hold until the owner releases its request;
  - a configurable transaction quantum that forces rotation between competing masters;
  - an optional fixed high-priority requester.
- Grants change only on transaction boundaries, so a burst is never split across masters.

Parameters:
- NREQ, 4, number of requesters; index width is 2 bits; valid values 2..4.
- QW, 4, width of the quantum counter and of cfg_quantum.

Ports:
- clk_i  input  1  Clock.
- rst_n  input  1  Reset. Asynchronous, active-low.
- req  input  NREQ  Per-master request: stb qualified by target-id match and not last-ack.
- ack_i  input  1  Slave ack for the currently granted master.
- lack_i  input  1  Slave last-ack; ack_i & lack_i marks transaction complete.
- cfg_quantum  input  QW  Max completed transactions per grant while others wait; 0 = unlimited.
- cfg_prio_en  input  1  Enables the fixed-priority requester.
- cfg_prio_id  input  2  Index of the fixed-priority requester.
- gnt  output  2  Granted requester index.
- gnt_vld  output  1  A grant is active.
- xfer_cnt  output  QW  Completed transactions in the current grant.

Behaviour:
- Reset values:
  - gnt = 0; gnt_vld = 0; xfer_cnt = 0.
  - Round-robin pointer last = NREQ-1, so the first search starts at index 0.
  - State = IDLE.
- Winner function, win(mask):
  - If cfg_prio_en and mask[cfg_prio_id]: winner = cfg_prio_id.
  - Otherwise: the first set bit searching upward from last+1, modulo NREQ.
  - When cfg_prio_id >= NREQ, priority is ignored.
- State IDLE:
  - If |req: on the next edge, gnt = win(req), gnt_vld = 1, last = gnt, xfer_cnt = 0, go to BUSY.
  - Latency from req rising to gnt_vld is one cycle.
  - If no req: gnt holds its previous value, so the slave-port mux stays stable.
- State BUSY, evaluated every cycle. The completion event done = ack_i & lack_i.
  - Release: !req[gnt] and no done.
    - Other requests pending: next edge gnt = win(req), gnt_vld stays 1, xfer_cnt = 0.
    - Nothing pending: gnt_vld = 0, gnt holds, go to IDLE.
  - done and req[gnt] still high: xfer_cnt increments.
    - Quantum reached means cfg_quantum != 0 and xfer_cnt+1 >= cfg_quantum.
    - Quantum reached and another req pending: next edge gnt = win(req with bit gnt masked), xfer_cnt = 0.
    - Quantum reached and no other request: grant kept, xfer_cnt = 0.
  - done and !req[gnt] in the same cycle: handled as a release; xfer_cnt = 0.
  - Priority requester never preempts mid-grant. It wins only at the next arbitration point: release or quantum.
  - xfer_cnt saturates at all-ones when cfg_quantum = 0.
- Boundary rules:
  - cfg_quantum lowered below xfer_cnt mid-grant: the next done triggers rotation (>= compare).
  - ack_i without lack_i (mid-burst beat) never counts and never rotates.
  - ack_i/lack_i while gnt_vld = 0 are ignored.
  - Reset asserted mid-grant: all state returns to reset values immediately (asynchronous). The first post-reset grant goes to the lowest requesting index, unless priority applies.
- Single always_ff for state and registers, plus a combinational winner function. No other outputs are combinational from req.

Test Plan:
- req=4'b0010 after reset → gnt_vld=1, gnt=1 one cycle later. Drop req → gnt_vld=0 next cycle, gnt stays 1.
- req=4'b0111 held, cfg_quantum=2, one done every 3 cycles → grant sequence 0,1,2,0. Each owner gets exactly 2 completions; xfer_cnt shows 0,1,0,...
- req=4'b0011, cfg_quantum=0 → master 0 keeps the grant for 20 completions; xfer_cnt saturates at 15.
- 4-beat burst (ack_i ×4, lack_i on beat 4) with cfg_quantum=1 and master 2 waiting → no switch until beat 4; gnt=2 on the cycle after lack_i.
- cfg_prio_en=1, cfg_prio_id=2, master 0 granted, req=4'b0101 → master 2 not granted mid-transfer. It is granted right after master 0's quantum or release, ahead of master 1 if both are pending.
- rst_n pulsed low while gnt=2 and gnt_vld=1 → gnt=0, gnt_vld=0, xfer_cnt=0 asynchronously. With req=4'b0110 after reset → gnt=1.

Source files
------------

// File: rtl/wb_arb_qos.sv
// QoS arbiter for a shared Wishbone slave port: round-robin with grant hold,
// a per-grant transaction quantum and an optional fixed-priority requester.
module wb_arb_qos #(
  parameter int NREQ = 4,
  parameter int QW   = 4
) (
  input  logic            clk_i,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            ack_i,
  input  logic            lack_i,
  input  logic [QW-1:0]   cfg_quantum,
  input  logic            cfg_prio_en,
  input  logic [1:0]      cfg_prio_id,
  output logic [1:0]      gnt,
  output logic            gnt_vld,
  output logic [QW-1:0]   xfer_cnt
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic [1:0]    last_q, last_d;
  logic [1:0]    gnt_d;
  logic          gnt_vld_d;
  logic [QW-1:0] xfer_d;
  logic [3:0]    req_w, req_others;
  logic          done, quantum_hit;
  logic [QW:0]   cnt_inc;

  // Priority requester first (if enabled and in range), else first set bit after last.
  function automatic logic [1:0] win(input logic [3:0] mask, input logic [1:0] last,
                                     input logic prio_en, input logic [1:0] prio_id);
    logic [1:0] w;
    logic [1:0] idx;
    logic       found;
    w     = '0;
    found = 1'b0;
    if (prio_en && (int'(prio_id) < NREQ) && mask[prio_id]) begin
      w     = prio_id;
      found = 1'b1;
    end
    for (int i = 1; i <= NREQ; i++) begin
      idx = 2'((int'(last) + i) % NREQ);
      if (!found && mask[idx]) begin
        w     = idx;
        found = 1'b1;
      end
    end
    return w;
  endfunction

  always_comb begin
    req_w            = '0;
    req_w[NREQ-1:0]  = req;
  end

  assign req_others  = req_w & ~(4'b0001 << gnt);
  assign done        = ack_i & lack_i;
  assign cnt_inc     = {1'b0, xfer_cnt} + (QW+1)'(1);
  assign quantum_hit = (cfg_quantum != '0) && (cnt_inc >= {1'b0, cfg_quantum});

  // NOTE: every variable gets its hold value first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt;
    gnt_vld_d = gnt_vld;
    xfer_d    = xfer_cnt;
    last_d    = last_q;
    case (state_q)
      IDLE: begin
        if (|req_w) begin
          gnt_d     = win(req_w, last_q, cfg_prio_en, cfg_prio_id);
          gnt_vld_d = 1'b1;
          last_d    = gnt_d;
          xfer_d    = '0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (!req_w[gnt]) begin
          // Owner released; a completion in the same cycle is folded into the release.
          xfer_d = '0;
          if (|req_w) begin
            gnt_d  = win(req_w, last_q, cfg_prio_en, cfg_prio_id);
            last_d = gnt_d;
          end else begin
            gnt_vld_d = 1'b0;
            state_d   = IDLE;
          end
        end else if (done) begin
          if (quantum_hit) begin
            xfer_d = '0;
            if (|req_others) begin
              gnt_d  = win(req_others, last_q, cfg_prio_en, cfg_prio_id);
              last_d = gnt_d;
            end
          end else begin
            xfer_d = cnt_inc[QW] ? '1 : cnt_inc[QW-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_q   <= 2'(NREQ-1);
      gnt      <= '0;
      gnt_vld  <= 1'b0;
      xfer_cnt <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gnt      <= gnt_d;
      gnt_vld  <= gnt_vld_d;
      xfer_cnt <= xfer_d;
    end
  end

endmodule
